// File: rtl/rsa_seq_pkg.sv
// rtl/rsa_seq_pkg.sv - shared state encoding, default parameters and counter sizing for the RSA job sequencer
package rsa_seq_pkg;

  localparam int DEF_WIDTH   = 128;
  localparam int DEF_SETTLE  = 2;
  localparam int DEF_TIMEOUT = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INV_START,
    ST_INV_WAIT,
    ST_EXP_START,
    ST_EXP_WAIT,
    ST_OUT_HOLD
  } seq_state_e;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rsa_phase_timer.sv
// rtl/rsa_phase_timer.sv - saturating per-phase wait counter with settle and timeout flags
module rsa_phase_timer
  import rsa_seq_pkg::*;
#(
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic settle_done_o,
  output logic timeout_o
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign settle_done_o = (cnt_q >= CW'(SETTLE));
  // Flags the edge on which the count would reach TIMEOUT, so a phase waits at most TIMEOUT cycles.
  assign timeout_o     = (({1'b0, cnt_q} + 1'b1) >= (CW + 1)'(TIMEOUT));

endmodule

// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - streaming job front-end that pulses the RSA control core through inverter and mod-exp phases
// Optional key cache (skip inverter phase on a repeated p/q) is enabled by defining RSA_KEY_CACHE_EN.
module rsa_job_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_p,
  input  logic [WIDTH-1:0]   in_q,
  input  logic               in_mode,
  input  logic [2*WIDTH-1:0] in_msg,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_q,
  output logic               core_encrypt_decrypt,
  output logic [2*WIDTH-1:0] core_msg_in,
  output logic               core_reset_inverter,
  output logic               core_reset_mod_exp,
  input  logic               core_inverter_finish,
  input  logic               core_mod_exp_finish,
  input  logic [2*WIDTH-1:0] core_msg_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_msg,
  output logic               out_err,
  output logic               busy
);

  seq_state_e         state_q;
  logic [WIDTH-1:0]   p_q, q_q;
  logic               mode_q;
  logic [2*WIDTH-1:0] msg_q, out_msg_q;
  logic               pulse_inv_q, pulse_exp_q, out_valid_q, out_err_q;
  logic               settle_done, timeout, accept, cache_hit;
  logic               inv_done, inv_abort, exp_done, exp_abort;

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  // A finish arriving on the timeout cycle still counts as success.
  assign inv_done  = (state_q == ST_INV_WAIT) && settle_done && core_inverter_finish;
  assign inv_abort = (state_q == ST_INV_WAIT) && !inv_done && timeout;
  assign exp_done  = (state_q == ST_EXP_WAIT) && settle_done && core_mod_exp_finish;
  assign exp_abort = (state_q == ST_EXP_WAIT) && !exp_done && timeout;

  rsa_phase_timer #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) u_timer (
    .clk_i         (clk),
    .reset_i       (reset),
    .clear_i       ((state_q == ST_INV_START) || (state_q == ST_EXP_START)),
    .settle_done_o (settle_done),
    .timeout_o     (timeout)
  );

`ifdef RSA_KEY_CACHE_EN
  logic [WIDTH-1:0] last_p_q, last_q_q;
  logic             cache_valid_q;

  assign cache_hit = cache_valid_q && (in_p == last_p_q) && (in_q == last_q_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      last_p_q      <= '0;
      last_q_q      <= '0;
    end else if (inv_done) begin
      cache_valid_q <= 1'b1;
      last_p_q      <= p_q;
      last_q_q      <= q_q;
    end else if (inv_abort || exp_abort) begin
      cache_valid_q <= 1'b0;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      q_q         <= '0;
      mode_q      <= 1'b0;
      msg_q       <= '0;
      out_msg_q   <= '0;
      pulse_inv_q <= 1'b0;
      pulse_exp_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      pulse_inv_q <= 1'b0;
      pulse_exp_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            p_q    <= in_p;
            q_q    <= in_q;
            mode_q <= in_mode;
            msg_q  <= in_msg;
            if (cache_hit) begin
              state_q     <= ST_EXP_START;
              pulse_exp_q <= 1'b1;
            end else begin
              state_q     <= ST_INV_START;
              pulse_inv_q <= 1'b1;
            end
          end
        end
        ST_INV_START: state_q <= ST_INV_WAIT;
        ST_INV_WAIT: begin
          if (inv_done) begin
            state_q     <= ST_EXP_START;
            pulse_exp_q <= 1'b1;
          end else if (inv_abort) begin
            state_q     <= ST_OUT_HOLD;
            out_msg_q   <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        ST_EXP_START: state_q <= ST_EXP_WAIT;
        ST_EXP_WAIT: begin
          if (exp_done || exp_abort) begin
            state_q     <= ST_OUT_HOLD;
            out_msg_q   <= exp_done ? core_msg_out : '0;
            out_err_q   <= exp_abort;
            out_valid_q <= 1'b1;
          end
        end
        ST_OUT_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_p               = p_q;
  assign core_q               = q_q;
  assign core_encrypt_decrypt = mode_q;
  assign core_msg_in          = msg_q;
  assign core_reset_inverter  = pulse_inv_q;
  assign core_reset_mod_exp   = pulse_exp_q;
  assign out_valid            = out_valid_q;
  assign out_msg              = out_msg_q;
  assign out_err              = out_err_q;
  assign busy                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb/tb_rsa_job_sequencer.sv - self-checking bench with a behavioural RSA core model and result scoreboard
module tb_rsa_job_sequencer;

  localparam int W       = 128;
  localparam int MW      = 2 * W;
  localparam int INV_LAT = 20;
  localparam int EXP_LAT = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_p = '0, in_q = '0;
  logic [MW-1:0] in_msg = '0;
  logic          in_ready, core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp;
  logic [W-1:0]  core_p, core_q;
  logic [MW-1:0] core_msg_in, out_msg;
  logic          out_valid, out_err, busy;

  logic          inv_arm = 1'b0, exp_arm = 1'b0, inv_fin = 1'b0, exp_fin = 1'b0, exp_hang = 1'b0;
  int            inv_left = 0, exp_left = 0;
  logic [MW-1:0] core_out = '0;

  int checks = 0, errors = 0;
  int inv_pulses = 0, exp_pulses = 0, both_seen = 0;

  typedef struct {
    logic [W-1:0]  p;
    logic [W-1:0]  q;
    logic          mode;
    logic [MW-1:0] msg;
    logic [MW-1:0] exp_msg;
    int            exp_inv;
  } vec_t;

  typedef struct {
    logic [MW-1:0] msg;
    logic          err;
  } res_t;

  res_t sb[$];
  vec_t tv[3];

  always #5 clk = ~clk;

  rsa_job_sequencer #(.WIDTH(W), .SETTLE(2), .TIMEOUT(64)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_p                 (in_p),
    .in_q                 (in_q),
    .in_mode              (in_mode),
    .in_msg               (in_msg),
    .core_p               (core_p),
    .core_q               (core_q),
    .core_encrypt_decrypt (core_encrypt_decrypt),
    .core_msg_in          (core_msg_in),
    .core_reset_inverter  (core_reset_inverter),
    .core_reset_mod_exp   (core_reset_mod_exp),
    .core_inverter_finish (inv_fin),
    .core_mod_exp_finish  (exp_fin),
    .core_msg_out         (core_out),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_msg              (out_msg),
    .out_err              (out_err),
    .busy                 (busy)
  );

  function automatic logic [MW-1:0] model_f(input logic [W-1:0] p, input logic [W-1:0] q,
                                            input logic mode, input logic [MW-1:0] msg);
    return msg ^ {q, p} ^ {MW{mode}};
  endfunction

  // Core model: finish drops one cycle after the start pulse and stays high once done.
  always @(posedge clk) begin
    inv_arm <= core_reset_inverter;
    exp_arm <= core_reset_mod_exp;
    if (inv_arm) begin
      inv_fin  <= 1'b0;
      inv_left <= INV_LAT;
    end else if (inv_left > 0) begin
      inv_left <= inv_left - 1;
      if (inv_left == 1) inv_fin <= 1'b1;
    end
    if (exp_arm) begin
      exp_fin  <= 1'b0;
      exp_left <= EXP_LAT;
    end else if (exp_left > 0) begin
      exp_left <= exp_left - 1;
      if (exp_left == 1 && !exp_hang) begin
        exp_fin  <= 1'b1;
        core_out <= model_f(core_p, core_q, core_encrypt_decrypt, core_msg_in);
      end
    end
  end

  always @(negedge clk) begin
    if (core_reset_inverter) inv_pulses++;
    if (core_reset_mod_exp) exp_pulses++;
    if (core_reset_inverter && core_reset_mod_exp) both_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic mode,
                          input logic [MW-1:0] msg);
    int k = 0;
    in_p = p; in_q = q; in_mode = mode; in_msg = msg; in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int k = 0;
    while (!out_valid && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_valid"}, out_valid, 1);
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_release"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  task automatic run_job(input string name, input logic [W-1:0] p, input logic [W-1:0] q,
                         input logic mode, input logic [MW-1:0] msg,
                         input logic [MW-1:0] exp_msg, input int exp_inv);
    int   i0, e0;
    res_t r;
    i0 = inv_pulses;
    e0 = exp_pulses;
    sb.push_back('{exp_msg, 1'b0});
    send_job(p, q, mode, msg);
    wait_valid(name, 600);
    r = sb.pop_front();
    check({name, "_msg"}, out_msg, r.msg);
    check({name, "_err"}, out_err, r.err);
    release_out(name);
    check({name, "_inv_pulses"}, inv_pulses - i0, exp_inv);
    check({name, "_exp_pulses"}, exp_pulses - e0, 1);
  endtask

  initial begin
    int   k, bad;
    res_t r;
    logic [W-1:0] p6, q6;

    tv[0] = '{128'd113680897410347, 128'd7999808077935876437321, 1'b0, 256'hb3000000000000, '0, 1};
    tv[1] = '{128'd7999808077935876437321, 128'd113680897410347, 1'b1, 256'he149, '0, 1};
    tv[2] = '{128'd1000003, 128'd998244353, 1'b0, 256'h1234_5678_9abc, '0, 1};
    for (int i = 0; i < 3; i++) tv[i].exp_msg = model_f(tv[i].p, tv[i].q, tv[i].mode, tv[i].msg);

    repeat (3) @(negedge clk);
    check("reset_in_ready_low", in_ready, 0);
    reset = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_outs", {out_valid, out_err, core_reset_inverter, core_reset_mod_exp}, 4'b0);
    check("reset_out_msg", out_msg, 0);
    check("reset_core_ops", {core_p, core_q, core_encrypt_decrypt}, 0);
    check("reset_core_msg", core_msg_in, 0);
    @(negedge clk);

    // Back-to-back table jobs: later jobs start with a stale finish still high.
    for (int i = 0; i < 3; i++)
      run_job($sformatf("vec%0d", i), tv[i].p, tv[i].q, tv[i].mode, tv[i].msg, tv[i].exp_msg, tv[i].exp_inv);

    // Consumer stalls for 10 cycles.
    sb.push_back('{model_f(128'd77, 128'd91, 1'b1, 256'hbeef), 1'b0});
    send_job(128'd77, 128'd91, 1'b1, 256'hbeef);
    wait_valid("stall", 600);
    r = sb.pop_front();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!out_valid || out_msg !== r.msg || out_err || in_ready || !busy) bad++;
      @(negedge clk);
    end
    check("stall_hold_bad_cycles", bad, 0);
    check("stall_msg", out_msg, r.msg);
    release_out("stall");

    // Mod-exp never finishes: abort TIMEOUT+1 cycles after the EXP_START pulse.
    exp_hang = 1'b1;
    sb.push_back('{'0, 1'b1});
    send_job(128'd101, 128'd103, 1'b0, 256'h55);
    k = 0;
    while (!core_reset_mod_exp && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("to_exp_pulse", core_reset_mod_exp, 1);
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("to_latency", k, 65);
    r = sb.pop_front();
    check("to_msg", out_msg, r.msg);
    check("to_err", out_err, r.err);
    release_out("to");
    exp_hang = 1'b0;

    // Reset in the middle of INV_WAIT.
    send_job(128'd211, 128'd223, 1'b0, 256'h77);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_state", {busy, in_ready, out_valid, out_err}, 4'b0100);
    check("midrst_pulses", {core_reset_inverter, core_reset_mod_exp}, 2'b00);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midrst_no_valid", bad, 0);
    run_job("after_rst", 128'd307, 128'd311, 1'b1, 256'h4242,
            model_f(128'd307, 128'd311, 1'b1, 256'h4242), 1);

    p6 = 128'd8475698667747010771;
    q6 = 128'd11297384090418420749;
`ifdef RSA_KEY_CACHE_EN
    run_job("cache_a", p6, q6, 1'b0, 256'hc0de, model_f(p6, q6, 1'b0, 256'hc0de), 1);
    run_job("cache_b", p6, q6, 1'b1, 256'hc0de, model_f(p6, q6, 1'b1, 256'hc0de), 0);
    run_job("cache_c", p6, q6 + 128'd2, 1'b0, 256'hc0de, model_f(p6, q6 + 128'd2, 1'b0, 256'hc0de), 1);
`else
    run_job("nocache_a", p6, q6, 1'b0, 256'hc0de, model_f(p6, q6, 1'b0, 256'hc0de), 1);
    run_job("nocache_b", p6, q6, 1'b1, 256'hc0de, model_f(p6, q6, 1'b1, 256'hc0de), 1);
`endif

    check("no_pulse_overlap", both_seen, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
